// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : host-to-device PS/2 transmitter for single command bytes.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_INH_LAST  = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_INH_END   = c_CNT_W'(INHIBIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_STOP_IDX  = 4'd9;
    localparam logic [1:0]         c_ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]         c_ERR_NAK     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_SEND     = 3'd3,
        S_ACK      = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic                  r_clk_filt;
    logic                  w_hist_low;
    logic                  w_hist_high;
    logic                  w_fe;
    logic                  w_edge;

    // Idle bus level is high, so the sync and filter chains reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    generate
        if (FILTER_LEN > 1) begin : g_filt_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_clk_hist <= '1;
                end else begin
                    r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
                end
            end
        end else begin : g_filt_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_clk_hist <= '1;
                end else begin
                    r_clk_hist <= r_clk_sync[1];
                end
            end
        end
    endgenerate

    assign w_hist_low  = ~|r_clk_hist;
    assign w_hist_high = &r_clk_hist;
    assign w_fe        = r_clk_filt & w_hist_low;
    assign w_edge      = w_fe | (~r_clk_filt & w_hist_high);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_filt <= 1'b1;
        end else if (w_hist_high) begin
            r_clk_filt <= 1'b1;
        end else if (w_hist_low) begin
            r_clk_filt <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           r_bitcnt;
    logic [3:0]           w_bitcnt_nxt;
    logic [9:0]           r_frame;
    logic [9:0]           w_frame_nxt;
    logic                 r_clk_oe;
    logic                 w_clk_oe_nxt;
    logic                 r_data_oe;
    logic                 w_data_oe_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [1:0]           r_err_code;
    logic [1:0]           w_err_code_nxt;
    logic                 w_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_frame    <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_frame    <= w_frame_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign w_active = (r_state == S_REQ) || (r_state == S_SEND) ||
                      (r_state == S_ACK) || (r_state == S_WAIT_REL);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bitcnt_nxt   = r_bitcnt;
        w_frame_nxt    = r_frame;
        w_clk_oe_nxt   = r_clk_oe;
        w_data_oe_nxt  = r_data_oe;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_frame_nxt    = {1'b1, ~^tx_data, tx_data};
                    w_err_code_nxt = 2'b00;
                    w_busy_nxt     = 1'b1;
                    w_clk_oe_nxt   = 1'b1;
                    w_data_oe_nxt  = 1'b0;
                    w_cnt_nxt      = '0;
                    w_bitcnt_nxt   = '0;
                    w_state_nxt    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Start bit goes out one cycle before the clock line is released.
                if (r_cnt == c_INH_END) begin
                    w_clk_oe_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_REQ;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_INH_LAST) begin
                        w_data_oe_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (w_fe) begin
                    w_data_oe_nxt = ~r_frame[0];
                    w_bitcnt_nxt  = 4'd1;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (w_fe) begin
                    w_data_oe_nxt = ~r_frame[r_bitcnt];
                    w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    if (r_bitcnt == c_STOP_IDX) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fe) begin
                    if (!r_data_sync[1]) begin
                        w_state_nxt = S_WAIT_REL;
                    end else begin
                        w_clk_oe_nxt   = 1'b0;
                        w_data_oe_nxt  = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = c_ERR_NAK;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
            S_WAIT_REL: begin
                if (r_clk_sync[1] && r_data_sync[1]) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase

        // Inactivity watchdog; a timeout overrides any completion in the same cycle.
        if (w_active) begin
            if (w_edge) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == c_TO_LAST) begin
                w_clk_oe_nxt   = 1'b0;
                w_data_oe_nxt  = 1'b0;
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b0;
                w_err_nxt      = 1'b1;
                w_err_code_nxt = c_ERR_TIMEOUT;
                w_state_nxt    = S_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign err_code    = r_err_code;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// tb_ps2_host_tx : directed bench with a PS/2 device model on a wired-AND bus.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch       = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .TIMEOUT_CYCLES(5000),
        .FILTER_LEN    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_total = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    int    both_cnt = 0;
    string cur_tag = "";

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %0h expected %0h", cur_tag, name, act, exp);
    endtask

    task automatic start_tx(input logic [7:0] d, output int inh);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
    endtask

    // Device side: clocks n_clk pulses, samples data on each rising edge,
    // drives the ACK bit after the stop bit and releases it on the 11th rise.
    task automatic dev_xfer(input int n_clk, input logic ack_bit, input logic inject,
                            output logic [9:0] bits);
        bits = '0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < n_clk; i++) begin
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = ps2_data_in;
            if (i == 9 && !ack_bit) dev_data_low = 1'b1;
            if (i == 10) dev_data_low = 1'b0;
            if (inject && i == 3) begin
                repeat (20) @(negedge clk);
                glitch   = 1'b1;
                tx_data  = 8'h33;
                tx_start = 1'b1;
                @(negedge clk);
                glitch   = 1'b0;
                tx_start = 1'b0;
                repeat (29) @(negedge clk);
            end else begin
                repeat (50) @(negedge clk);
            end
        end
    endtask

    task automatic run_case(input vec_t v, input logic inject);
        int         inh;
        int         d0;
        int         e0;
        int         n;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(v.data, inh);
        check("inhibit_len", inh, 100);
        check("rts_clk_oe", ps2_clk_oe, 1);
        check("rts_data_oe", ps2_data_oe, 1);
        @(negedge clk);
        check("req_clk_released", ps2_clk_oe, 0);
        check("req_start_bit", ps2_data_oe, 1);
        dev_xfer(11, v.ack, inject, bits);
        n = 0;
        while (tx_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check("frame_bits", bits, v.exp_bits);
        check("done_pulses", done_cnt - d0, v.exp_done);
        check("err_pulses", err_cnt - e0, v.exp_err);
        check("err_code", err_code, v.exp_code);
        check("busy_end", tx_busy, 0);
        check("oe_end", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vec_t v_glitch;
        vec_t v_after_rst;
        int   inh;
        int   n;
        int   d0;
        int   e0;
        logic [9:0] bits;

        vecs[0] = '{8'hED, 1'b0, 10'h3ED, 1, 0, 2'b00};
        vecs[1] = '{8'h01, 1'b0, 10'h201, 1, 0, 2'b00};
        vecs[2] = '{8'hFF, 1'b1, 10'h3FF, 0, 1, 2'b10};
        vecs[3] = '{8'h00, 1'b0, 10'h300, 1, 0, 2'b00};
        v_glitch    = '{8'h5A, 1'b0, 10'h35A, 1, 0, 2'b00};
        v_after_rst = '{8'hED, 1'b0, 10'h3ED, 1, 0, 2'b00};

        // Reset state
        cur_tag = "reset";
        repeat (5) @(negedge clk);
        check("outs_in_reset", {tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("outs_after_reset", {tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe}, 0);

        for (int i = 0; i < 4; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_case(vecs[i], 1'b0);
        end

        // Device never clocks: watchdog abort
        cur_tag = "timeout";
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5, inh);
        @(negedge clk);
        check("req_entered", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        n = 0;
        while (!tx_err && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("latency_window", (n >= 5000 && n <= 5020) ? 1 : 0, 1);
        check("err_code", err_code, 2'b01);
        check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        check("err_pulses", err_cnt - e0, 1);
        check("done_pulses", done_cnt - d0, 0);
        check("busy", tx_busy, 0);

        // Mid-SEND tx_start with other data plus a one-cycle clock glitch
        cur_tag = "glitch";
        run_case(v_glitch, 1'b1);

        // Asynchronous reset while bit 4 is driven
        cur_tag = "midrst";
        start_tx(8'hED, inh);
        @(negedge clk);
        dev_xfer(4, 1'b0, 1'b0, bits);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        check("bit4_driven_low", ps2_data_oe, 1);
        check("busy_before", tx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        check("busy_cleared", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (100) @(negedge clk);

        cur_tag = "after_rst";
        run_case(v_after_rst, 1'b0);

        cur_tag = "global";
        check("done_err_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
